// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
//   Multicycle sequencing state machine for the ARM multicycle processor.
//   Walks each instruction through fetch, decode, execute, memory and
//   writeback steps, producing the per-cycle datapath selects and the
//   unconditioned write strobes that the downstream condition logic qualifies.
//
// Ports
//   clk        in   1  processor clock, rising-edge active
//   reset      in   1  synchronous, active-high; forces FETCH and zeroes outputs
//   Op         in   2  Instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undef
//   Funct      in   6  Instr[25:20]: [5]=I, [2]=B, [0]=L
//   IRWrite    out  1  load instruction register (FETCH only)
//   AdrSrc     out  1  memory address select: 0=PC, 1=Result
//   ALUSrcA    out  2  00=register A, 01=PC
//   ALUSrcB    out  2  00=WriteData, 01=ExtImm, 10=constant 4
//   ResultSrc  out  2  00=ALUOut, 01=Data register, 10=ALUResult
//   ALUOp      out  1  1=ALU decoder uses Funct, 0=force ADD
//   NextPC     out  1  unconditional PC update request
//   RegW       out  1  register write request (pre-condition)
//   MemW       out  1  memory write request (pre-condition)
//   Branch     out  1  branch request (pre-condition)
//   LDRB       out  1  byte-load select for the read-data path
//
// Configuration
//   MAIN_FSM_LDRB_EN  defined: LDRB follows Funct[2] in MEMREAD/MEMWB.
//                     undefined: LDRB tied to 0, byte loads behave as word LDR.
//
// Outputs are a Moore decode of the state register (LDRB additionally uses
// Funct[2]). They are gated combinationally by reset so no strobe can fire in
// any cycle where reset is high, including the very cycle it first appears.
// -----------------------------------------------------------------------------
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       LDRB
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic   byte_sel_s;

`ifdef MAIN_FSM_LDRB_EN
    logic unused_funct_s;
    assign unused_funct_s = ^{Funct[4:3], Funct[1]};
    assign byte_sel_s     = Funct[2];
`else
    // Byte loads run as word loads; Funct[2] has no effect in this build.
    logic unused_funct_s;
    assign unused_funct_s = ^{Funct[4:1]};
    assign byte_sel_s     = 1'b0;
`endif

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; Op/Funct come straight from the IR, which only
    // reloads in FETCH, so they are stable from DECODE onward.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5]) begin
                            state_d = EXECUTEI;
                        end else begin
                            state_d = EXECUTER;
                        end
                    end
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    2'b11:   state_d = UNKNOWN;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                if (Funct[0]) begin
                    state_d = MEMREAD;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            UNKNOWN:  state_d = FETCH;
            // Unused encodings recover to FETCH on the next edge.
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode, all zero while reset is high.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        LDRB      = 1'b0;
        if (reset) begin
            IRWrite = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    AdrSrc    = 1'b0;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                DECODE: begin
                    // PC+8 is formed here so R15 reads see the ARM-visible PC.
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                MEMADR: begin
                    ALUSrcA   = 2'b00;
                    ALUSrcB   = 2'b01;
                end
                MEMREAD: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = 2'b00;
                    LDRB      = byte_sel_s;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    LDRB      = byte_sel_s;
                end
                MEMWRITE: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = 2'b00;
                    MemW      = 1'b1;
                end
                EXECUTER: begin
                    ALUSrcA   = 2'b00;
                    ALUSrcB   = 2'b00;
                    ALUOp     = 1'b1;
                end
                EXECUTEI: begin
                    ALUSrcA   = 2'b00;
                    ALUSrcB   = 2'b01;
                    ALUOp     = 1'b1;
                end
                ALUWB: begin
                    ResultSrc = 2'b00;
                    RegW      = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA   = 2'b00;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                // UNKNOWN executes as a NOP: every output stays at 0.
                UNKNOWN: IRWrite = 1'b0;
                default: IRWrite = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle sequencing state machine for the ARM multicycle processor. It sits inside the instruction decoder, directly upstream of the condition logic. From the current instruction's Op and Funct fields it walks each instruction through the fetch, decode, execute, memory and writeback steps. It produces the per-cycle datapath selects and the unconditioned write strobes (NextPC, RegW, MemW, Branch), which the condition logic then qualifies.

## Interface
Parameters: none.

- clk  input  1  processor clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, `clk`, and one reset, `reset`
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  input  6  Instr[25:20]: [5]=I (immediate), [2]=B (byte), [0]=L (load)
- IRWrite  output  1  load instruction register
- AdrSrc  output  1  memory address select: 0=PC, 1=Result
- ALUSrcA  output  2  00=register A, 01=PC, 10/11 unused (never driven)
- ALUSrcB  output  2  00=WriteData register, 01=ExtImm, 10=constant 4, 11 unused
- ResultSrc  output  2  00=ALUOut, 01=Data register, 10=ALUResult
- ALUOp  output  1  1=ALU decoder uses Funct; 0=force ADD
- NextPC  output  1  unconditional PC update request
- RegW  output  1  register write request, before condition check
- MemW  output  1  memory write request, before condition check
- Branch  output  1  branch request, before condition check
- LDRB  output  1  byte-load select for the read-data path

## Operation
- Moore FSM, 4-bit state register, 11 encoded states. Outputs are decoded from the state, plus Funct[2] for LDRB only.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=10 -> BRANCH.
    - Op=11 -> UNKNOWN.
  - MEMADR -> MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER or EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH.
  - Unused encodings -> FETCH on the next edge.
- Outputs per state; any output not listed is 0:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. This computes PC+8 for R15 reads.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all outputs 0. The undefined instruction is executed as a NOP.
- LDRB = Funct[2] in MEMREAD and MEMWB. It is 0 in all other states, and 0 for stores.
- Op and Funct are stable from DECODE through the end of the instruction, because IR loads only in FETCH. The FSM samples them combinationally and does not latch them.

## Timing
- Reset asserted at an edge: state <= FETCH.
- While reset is high, every output is forced to 0, including IRWrite and NextPC. This prevents writes during reset.
- First cycle after reset deasserts: state is FETCH and FETCH outputs are active.
- Reset asserted mid-instruction: the instruction is aborted. No further strobes are driven from the cycle reset is seen high, and the FSM restarts at FETCH.
- Cycles per instruction, FETCH through the last state:
  - LDR/LDRB: 5.
  - STR: 4.
  - Data-processing (register or immediate): 4.
  - Branch: 3.
  - Undefined: 3.
- At most one of RegW, MemW and Branch is high in any cycle. IRWrite is high only in FETCH.

## Configuration
- Macro: MAIN_FSM_LDRB_EN.
- Defined: LDRB is driven as described under Operation.
- Undefined: LDRB is tied to 0. A byte load then executes as a word LDR with identical state sequence and timing; Funct[2] is ignored.

## Test plan
- Reset held 3 cycles, then released -> all outputs 0 during reset. Next cycle: FETCH with IRWrite=1, NextPC=1, ALUSrcB=10.
- Op=00, Funct=6'b101000 (ADD imm) -> sequence FETCH, DECODE, EXECUTEI (ALUSrcB=01, ALUOp=1), ALUWB (RegW=1), FETCH. Total 4 cycles.
- Op=01, Funct=6'b011101 (LDRB) -> sequence FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1, LDRB=1), MEMWB (ResultSrc=01, RegW=1, LDRB=1), FETCH. With the macro undefined, LDRB=0 throughout.
- Op=01, Funct=6'b011000 (STR) -> sequence through MEMWRITE with MemW=1 for exactly 1 cycle, then FETCH. RegW stays 0.
- Op=10 -> BRANCH with Branch=1, ALUSrcA=00, ALUSrcB=01. Op=11 -> UNKNOWN with all outputs 0, then FETCH.
- Reset pulsed for 1 cycle during MEMREAD -> MEMWB is never entered and RegW is never asserted. FETCH follows the reset cycle.
